mem_arbiter: RTL and testbench

- Two-port arbiter that shares one data memory between two requesters: port 0 (load/store unit) and port 1 (secondary master, e.g. a debug or DMA loader).
- The memory has a synchronous write and a combinational read, word-indexed by address[31:2].
- The arbiter grants at most one access per cycle using round-robin priority.
- It drives the memory port, registers read data and raises a one-cycle completion pulse per access. Out-of-range and misaligned accesses are flagged.

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port.
// slave = the arbiter; master = the requesters and the memory.
interface mem_arbiter_if;
   logic        p0_req, p0_we, p0_gnt, p0_done, p0_err;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic        p1_req, p1_we, p1_gnt, p1_done, p1_err;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic        mem_write;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  mem_read_data,
      output p0_gnt, p0_done, p0_rdata, p0_err,
      output p1_gnt, p1_done, p1_rdata, p1_err,
      output mem_write, mem_address, mem_write_data
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output mem_read_data,
      input  p0_gnt, p0_done, p0_rdata, p0_err,
      input  p1_gnt, p1_done, p1_rdata, p1_err,
      input  mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-write / combinational-read
// memory between two requesters, with registered completion per port.

// Per-port completion stage: done/err/rdata one cycle after the grant.
module mem_arb_port #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              gnt,
   input  logic              we,
   input  logic              bad,
   input  logic [DATA_W-1:0] rd_in,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata
);
   localparam int STAGES = 1;
   logic [STAGES:0] vld_pipe;

   assign vld_pipe[0] = gnt;
   assign done        = vld_pipe[STAGES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe[STAGES:1] <= '0;
         err                <= 1'b0;
         rdata              <= '0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         err                <= gnt & bad;
         // stores leave the last load data in place
         if (gnt && !we) rdata <= bad ? '0 : rd_in;
      end
   end
endmodule

module mem_arbiter #(
   parameter int DEPTH_WORDS = 64,
   parameter int DATA_W      = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   mem_arbiter_if.slave bus
);
   localparam int          NUM_PORTS = 2;
   localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) * 33'd4;

   typedef struct packed {
      logic              we;
      logic [31:0]       addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   req_t [NUM_PORTS-1:0]              rq;
   logic [NUM_PORTS-1:0]              req, gnt, bad, done, err;
   logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata;
   logic                              prio, sel;
   req_t                              cur;

   assign req   = {bus.p1_req, bus.p0_req};
   assign rq[0] = {bus.p0_we, bus.p0_addr, bus.p0_wdata};
   assign rq[1] = {bus.p1_we, bus.p1_addr, bus.p1_wdata};

   // grants are gated by reset so nothing reaches memory while held in reset
   always_comb begin
      gnt = '0;
      if (reset_n) begin
         if (req[0] && (!req[1] || !prio)) gnt[0] = 1'b1;
         else if (req[1])                  gnt[1] = 1'b1;
      end
   end

   // idle falls through to port 0's fields
   assign sel                = gnt[1];
   assign cur                = rq[sel];
   assign bus.mem_address    = cur.addr;
   assign bus.mem_write_data = cur.wdata;
   assign bus.mem_write      = (|gnt) & cur.we & ~bad[sel];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  prio <= 1'b0;
      else if (|gnt) prio <= ~sel;
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign bad[i] = (rq[i].addr[1:0] != 2'b00) | ({1'b0, rq[i].addr} >= LIMIT);

      mem_arb_port #(.DATA_W(DATA_W)) u_port (
         .clk     (clk),
         .reset_n (reset_n),
         .gnt     (gnt[i]),
         .we      (rq[i].we),
         .bad     (bad[i]),
         .rd_in   (bus.mem_read_data),
         .done    (done[i]),
         .err     (err[i]),
         .rdata   (rdata[i])
      );
   end

   assign bus.p0_gnt   = gnt[0];
   assign bus.p1_gnt   = gnt[1];
   assign bus.p0_done  = done[0];
   assign bus.p1_done  = done[1];
   assign bus.p0_err   = err[0];
   assign bus.p1_err   = err[1];
   assign bus.p0_rdata = rdata[0];
   assign bus.p1_rdata = rdata[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a random run
// against a transaction-level model (winner choice, shadow memory, expected completions).
module tb_mem_arbiter;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   mem_arbiter_if bus();

   mem_arbiter #(.DEPTH_WORDS(DEPTH), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // attached memory: synchronous write, combinational read
   logic [31:0] mem [DEPTH];
   int wr_in_rst = 0;
   assign bus.mem_read_data = mem[bus.mem_address[7:2]];

   function automatic logic [31:0] init_word(int i);
      return 32'hA500_0000 ^ (i * 32'h0001_0203);
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (bus.mem_write) begin
            mem[bus.mem_address[7:2]] <= bus.mem_write_data;
            if (!reset_n) wr_in_rst++;
         end
      end
   end

   int total = 0;
   int nbad  = 0;

   // reference model state
   logic        m_prio;
   logic [31:0] ref_mem [DEPTH];
   logic [1:0]  exp_gnt, exp_done, exp_err;
   logic        exp_mw;
   logic [31:0] exp_rd [2];

   function automatic logic is_bad(logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
   endfunction

   // decide this cycle's winner from the current requests and update the model
   task automatic predict();
      int win;
      logic [31:0] a, wd;
      logic w;
      if (bus.p0_req && bus.p1_req) win = int'(m_prio);
      else if (bus.p0_req)          win = 0;
      else if (bus.p1_req)          win = 1;
      else                          win = -1;
      exp_gnt = 2'b00; exp_done = 2'b00; exp_err = 2'b00; exp_mw = 1'b0;
      if (win >= 0) begin
         a  = (win == 1) ? bus.p1_addr  : bus.p0_addr;
         w  = (win == 1) ? bus.p1_we    : bus.p0_we;
         wd = (win == 1) ? bus.p1_wdata : bus.p0_wdata;
         exp_gnt[win]  = 1'b1;
         exp_done[win] = 1'b1;
         exp_err[win]  = is_bad(a);
         if (!w) exp_rd[win] = is_bad(a) ? 32'h0 : ref_mem[a >> 2];
         else if (!is_bad(a)) begin
            exp_mw = 1'b1;
            ref_mem[a >> 2] = wd;
         end
         m_prio = (win == 0);
      end
   endtask

   task automatic model_reset();
      m_prio = 1'b0;
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      exp_done = 2'b00; exp_err = 2'b00; exp_gnt = 2'b00; exp_mw = 1'b0;
   endtask

   task automatic drive(int p, logic rq, logic we, logic [31:0] a, logic [31:0] wd);
      if (p == 0) begin bus.p0_req = rq; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = wd; end
      else        begin bus.p1_req = rq; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = wd; end
   endtask

   task automatic idle();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic apply_reset();
      idle();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(0, 1'b1, 1'b1, 32'h10, 32'h55);
      drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
      #1;
      total++;
      if ({bus.p1_gnt, bus.p0_gnt} !== 2'b00 || bus.mem_write !== 1'b0) begin
         nbad++;
         $display("FAIL reset_gnt: gnt=%b mw=%b want gnt=00 mw=0", {bus.p1_gnt, bus.p0_gnt}, bus.mem_write);
      end
      @(posedge clk); #1;
      total++;
      if ({bus.p1_done, bus.p0_done, bus.p1_err, bus.p0_err} !== 4'b0 ||
          bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
         nbad++;
         $display("FAIL reset_regs: done=%b err=%b rd0=%h rd1=%h want all 0",
                  {bus.p1_done, bus.p0_done}, {bus.p1_err, bus.p0_err}, bus.p0_rdata, bus.p1_rdata);
      end
      idle();
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_store_load();
      int mw_cnt = 0, done_cnt = 0;
      apply_reset();
      for (int c = 0; c < 3; c++) begin
         if (c == 0)      drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
         else if (c == 1) drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
         else             idle();
         predict(); #1;
         if (bus.mem_write === 1'b1) mw_cnt++;
         total++;
         if ({bus.p1_gnt, bus.p0_gnt} !== exp_gnt || bus.mem_write !== exp_mw) begin
            nbad++;
            $display("FAIL store_load_gnt c%0d: gnt=%b mw=%b want gnt=%b mw=%b", c,
                     {bus.p1_gnt, bus.p0_gnt}, bus.mem_write, exp_gnt, exp_mw);
         end
         @(posedge clk); #1;
         if (bus.p0_done === 1'b1) done_cnt++;
         total++;
         if (bus.p0_done !== exp_done[0] || bus.p0_err !== exp_err[0] || bus.p0_rdata !== exp_rd[0]) begin
            nbad++;
            $display("FAIL store_load_done c%0d: done=%b err=%b rd=%h want done=%b err=%b rd=%h", c,
                     bus.p0_done, bus.p0_err, bus.p0_rdata, exp_done[0], exp_err[0], exp_rd[0]);
         end
         @(negedge clk);
      end
      total++;
      if (bus.p0_rdata !== 32'hDEADBEEF || mw_cnt != 1 || done_cnt != 2) begin
         nbad++;
         $display("FAIL store_load_sum: rd=%h mw_cycles=%0d dones=%0d want DEADBEEF 1 2",
                  bus.p0_rdata, mw_cnt, done_cnt);
      end
   endtask

   task automatic test_contention();
      int d0 = 0, d1 = 0;
      logic [1:0] want;
      apply_reset();
      drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
      for (int c = 0; c < 6; c++) begin
         predict(); #1;
         want = (c % 2 == 0) ? 2'b01 : 2'b10;
         total++;
         if ({bus.p1_gnt, bus.p0_gnt} !== want || {bus.p1_gnt, bus.p0_gnt} !== exp_gnt) begin
            nbad++;
            $display("FAIL contention_gnt c%0d: gnt=%b want %b", c, {bus.p1_gnt, bus.p0_gnt}, want);
         end
         @(posedge clk); #1;
         if (bus.p0_done === 1'b1) d0++;
         if (bus.p1_done === 1'b1) d1++;
         total++;
         if ({bus.p1_done, bus.p0_done} !== exp_done || bus.p0_rdata !== exp_rd[0] || bus.p1_rdata !== exp_rd[1]) begin
            nbad++;
            $display("FAIL contention_done c%0d: done=%b rd0=%h rd1=%h want done=%b rd0=%h rd1=%h", c,
                     {bus.p1_done, bus.p0_done}, bus.p0_rdata, bus.p1_rdata, exp_done, exp_rd[0], exp_rd[1]);
         end
         @(negedge clk);
      end
      idle();
      total++;
      if (d0 != 3 || d1 != 3) begin
         nbad++;
         $display("FAIL contention_count: d0=%0d d1=%0d want 3 3", d0, d1);
      end
   endtask

   task automatic test_bad_store();
      logic [31:0] snap [DEPTH];
      logic [31:0] addrs [2];
      int diffs = 0;
      addrs[0] = 32'h12; addrs[1] = 32'h100;
      snap = mem;
      for (int c = 0; c < 2; c++) begin
         drive(1, 1'b1, 1'b1, addrs[c], 32'h0BAD_0BAD);
         predict(); #1;
         total++;
         if (bus.p1_gnt !== 1'b1 || bus.mem_write !== 1'b0) begin
            nbad++;
            $display("FAIL bad_store_gnt %h: gnt=%b mw=%b want gnt=1 mw=0", addrs[c], bus.p1_gnt, bus.mem_write);
         end
         @(posedge clk); #1;
         total++;
         if (bus.p1_done !== 1'b1 || bus.p1_err !== 1'b1 || bus.p1_rdata !== exp_rd[1]) begin
            nbad++;
            $display("FAIL bad_store_done %h: done=%b err=%b rd=%h want 1 1 %h", addrs[c],
                     bus.p1_done, bus.p1_err, bus.p1_rdata, exp_rd[1]);
         end
         @(negedge clk);
      end
      idle();
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== snap[i]) diffs++;
      total++;
      if (diffs != 0) begin
         nbad++;
         $display("FAIL bad_store_mem: %0d words changed want 0", diffs);
      end
   endtask

   task automatic test_back_to_back();
      int dn = 0;
      for (int c = 0; c < 4; c++) begin
         drive(0, 1'b1, 1'b0, 32'(c * 4), 32'h0);
         predict(); #1;
         total++;
         if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
            nbad++;
            $display("FAIL b2b_gnt c%0d: gnt=%b want 01", c, {bus.p1_gnt, bus.p0_gnt});
         end
         @(posedge clk); #1;
         if (bus.p0_done === 1'b1) dn++;
         total++;
         if (bus.p0_rdata !== exp_rd[0] || bus.p0_err !== 1'b0) begin
            nbad++;
            $display("FAIL b2b_rdata c%0d: rd=%h err=%b want %h 0", c, bus.p0_rdata, bus.p0_err, exp_rd[0]);
         end
         @(negedge clk);
      end
      drive(0, 1'b1, 1'b0, 32'h8, 32'h0);
      drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
      predict(); #1;
      total++;
      if (dn != 4 || {bus.p1_gnt, bus.p0_gnt} !== 2'b10) begin
         nbad++;
         $display("FAIL b2b_prio: dones=%0d gnt=%b want 4 10", dn, {bus.p1_gnt, bus.p0_gnt});
      end
      @(posedge clk); #1;
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset_mid();
      drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
      #1;
      total++;
      if (bus.p0_gnt !== 1'b1 || bus.mem_write !== 1'b1) begin
         nbad++;
         $display("FAIL midrst_pre: gnt=%b mw=%b want 1 1", bus.p0_gnt, bus.mem_write);
      end
      #1 reset_n = 1'b0;
      #1;
      total++;
      if (bus.p0_gnt !== 1'b0 || bus.mem_write !== 1'b0) begin
         nbad++;
         $display("FAIL midrst_gnt: gnt=%b mw=%b want 0 0", bus.p0_gnt, bus.mem_write);
      end
      @(posedge clk); #1;
      total++;
      if (bus.p0_done !== 1'b0 || bus.p0_rdata !== 32'h0) begin
         nbad++;
         $display("FAIL midrst_done: done=%b rd=%h want 0 0", bus.p0_done, bus.p0_rdata);
      end
      #1;
      reset_n = 1'b1;
      idle();
      model_reset();
      @(negedge clk);
      total++;
      if (mem[8] !== ref_mem[8] || wr_in_rst != 0) begin
         nbad++;
         $display("FAIL midrst_mem: mem8=%h want %h writes_in_reset=%0d", mem[8], ref_mem[8], wr_in_rst);
      end
      drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
      predict(); #1;
      total++;
      if ({bus.p1_gnt, bus.p0_gnt} !== 2'b01) begin
         nbad++;
         $display("FAIL midrst_prio: gnt=%b want 01", {bus.p1_gnt, bus.p0_gnt});
      end
      @(posedge clk); #1;
      @(negedge clk);
      idle();
   endtask

   task automatic test_last_word();
      drive(0, 1'b1, 1'b0, 32'hFC, 32'h0);
      predict();
      @(posedge clk); #1;
      total++;
      if (bus.p0_done !== 1'b1 || bus.p0_err !== 1'b0 || bus.p0_rdata !== mem[63] || bus.p0_rdata !== exp_rd[0]) begin
         nbad++;
         $display("FAIL last_word: done=%b err=%b rd=%h want 1 0 %h", bus.p0_done, bus.p0_err, bus.p0_rdata, mem[63]);
      end
      @(negedge clk);
      idle();
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return $urandom();
         1:       return {24'h0, 2'(0), $urandom_range(0, 63) * 4 + $urandom_range(1, 3)} ;
         default: return 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
   endfunction

   task automatic test_random();
      logic pend0 = 1'b0, pend1 = 1'b0;
      int diffs = 0;
      for (int c = 0; c < 400; c++) begin
         if (!pend0 || $urandom_range(0, 7) == 0)
            drive(0, $urandom_range(0, 2) != 0, 1'($urandom), rand_addr(), $urandom());
         if (!pend1 || $urandom_range(0, 7) == 0)
            drive(1, $urandom_range(0, 2) != 0, 1'($urandom), rand_addr(), $urandom());
         predict(); #1;
         pend0 = bus.p0_req && !exp_gnt[0];
         pend1 = bus.p1_req && !exp_gnt[1];
         total++;
         if ({bus.p1_gnt, bus.p0_gnt} !== exp_gnt || bus.mem_write !== exp_mw) begin
            nbad++;
            $display("FAIL rand_gnt c%0d: gnt=%b mw=%b want gnt=%b mw=%b", c,
                     {bus.p1_gnt, bus.p0_gnt}, bus.mem_write, exp_gnt, exp_mw);
         end
         @(posedge clk); #1;
         total++;
         if ({bus.p1_done, bus.p0_done} !== exp_done || {bus.p1_err, bus.p0_err} !== exp_err ||
             bus.p0_rdata !== exp_rd[0] || bus.p1_rdata !== exp_rd[1]) begin
            nbad++;
            $display("FAIL rand_done c%0d: done=%b err=%b rd0=%h rd1=%h want %b %b %h %h", c,
                     {bus.p1_done, bus.p0_done}, {bus.p1_err, bus.p0_err}, bus.p0_rdata, bus.p1_rdata,
                     exp_done, exp_err, exp_rd[0], exp_rd[1]);
         end
         @(negedge clk);
      end
      idle();
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
      total++;
      if (diffs != 0 || wr_in_rst != 0) begin
         nbad++;
         $display("FAIL rand_mem: %0d words differ, writes_in_reset=%0d want 0 0", diffs, wr_in_rst);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      model_reset();
      idle();
      #2;
      test_reset();
      test_store_load();
      test_contention();
      test_bad_store();
      test_back_to_back();
      test_reset_mid();
      test_last_word();
      test_random();
      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end
endmodule
